// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating stall-cycle counter.
module idex_hazard_reg #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_alusrc,
  input  logic [3:0]        id_aluop,
  input  logic              flush,
  output logic              stall,
  output logic              idex_valid,
  output logic [REG_AW-1:0] idexregrs,
  output logic [REG_AW-1:0] idexregrt,
  output logic [REG_AW-1:0] idexregrd,
  output logic [DATA_W-1:0] idex_rs_data,
  output logic [DATA_W-1:0] idex_rt_data,
  output logic [DATA_W-1:0] idex_imm,
  output logic              idex_regwrite,
  output logic              idex_memread,
  output logic              idex_memwrite,
  output logic              idex_memtoreg,
  output logic              idex_alusrc,
  output logic [3:0]        idex_aluop,
  output logic [CNT_W-1:0]  stall_count
);

  logic rs_match;
  logic rt_match;
  logic hazard;
  logic bubble;
  logic count_max;

  // A load in EX whose destination feeds the instruction in ID cannot be forwarded in time.
  always_comb begin
    rs_match  = (idexregrd == id_rs);
    rt_match  = id_uses_rt & (idexregrd == id_rt);
    hazard    = id_valid & idex_valid & idex_memread & (idexregrd != '0) &
                (rs_match | rt_match);
    stall     = hazard & ~flush & ~rst;
    bubble    = flush | stall;
    count_max = &stall_count;
  end

  // A bubble zeroes idexregrd too, so the forwarding unit never matches it.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      idex_valid    <= 1'b0;
      idexregrs     <= '0;
      idexregrt     <= '0;
      idexregrd     <= '0;
      idex_rs_data  <= '0;
      idex_rt_data  <= '0;
      idex_imm      <= '0;
      idex_regwrite <= 1'b0;
      idex_memread  <= 1'b0;
      idex_memwrite <= 1'b0;
      idex_memtoreg <= 1'b0;
      idex_alusrc   <= 1'b0;
      idex_aluop    <= '0;
    end else begin
      idex_valid    <= id_valid;
      idexregrs     <= id_rs;
      idexregrt     <= id_rt;
      idexregrd     <= id_rd;
      idex_rs_data  <= id_rs_data;
      idex_rt_data  <= id_rt_data;
      idex_imm      <= id_imm;
      idex_regwrite <= id_regwrite;
      idex_memread  <= id_memread;
      idex_memwrite <= id_memwrite;
      idex_memtoreg <= id_memtoreg;
      idex_alusrc   <= id_alusrc;
      idex_aluop    <= id_aluop;
    end
  end

  // Saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && !count_max) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Bench for idex_hazard_reg: directed load-use scenarios plus randomized traffic
// checked against a behavioural model of the EX stage contents.
module tb_idex_hazard_reg;

  typedef struct packed {
    logic        valid;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  rd;
    logic        uses_rt;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic [3:0]  aluop;
  } instr_t;

  logic clk = 1'b0;
  logic rst, flush;
  instr_t id;
  instr_t ex;
  logic [15:0] m_cnt;
  logic [3:0]  m_cnt_s;
  int errors = 0;
  int checks = 0;

  logic        stall, idex_valid, idex_regwrite, idex_memread, idex_memwrite;
  logic        idex_memtoreg, idex_alusrc;
  logic [3:0]  idexregrs, idexregrt, idexregrd, idex_aluop;
  logic [15:0] idex_rs_data, idex_rt_data, idex_imm, stall_count;

  logic        stall_s, valid_s, regwrite_s, memread_s, memwrite_s, memtoreg_s, alusrc_s;
  logic [3:0]  rs_s, rt_s, rd_s, aluop_s, count_s;
  logic [15:0] rs_data_s, rt_data_s, imm_s;

  always #5 clk = ~clk;

  idex_hazard_reg dut (
    .clk(clk), .rst(rst), .id_valid(id.valid), .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
    .id_uses_rt(id.uses_rt), .id_rs_data(id.rs_data), .id_rt_data(id.rt_data), .id_imm(id.imm),
    .id_regwrite(id.regwrite), .id_memread(id.memread), .id_memwrite(id.memwrite),
    .id_memtoreg(id.memtoreg), .id_alusrc(id.alusrc), .id_aluop(id.aluop), .flush(flush),
    .stall(stall), .idex_valid(idex_valid), .idexregrs(idexregrs), .idexregrt(idexregrt),
    .idexregrd(idexregrd), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
    .idex_imm(idex_imm), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .idex_memwrite(idex_memwrite), .idex_memtoreg(idex_memtoreg), .idex_alusrc(idex_alusrc),
    .idex_aluop(idex_aluop), .stall_count(stall_count)
  );

  // Narrow counter copy so saturation is reachable within a short run.
  idex_hazard_reg #(.DATA_W(16), .REG_AW(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id.valid), .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
    .id_uses_rt(id.uses_rt), .id_rs_data(id.rs_data), .id_rt_data(id.rt_data), .id_imm(id.imm),
    .id_regwrite(id.regwrite), .id_memread(id.memread), .id_memwrite(id.memwrite),
    .id_memtoreg(id.memtoreg), .id_alusrc(id.alusrc), .id_aluop(id.aluop), .flush(flush),
    .stall(stall_s), .idex_valid(valid_s), .idexregrs(rs_s), .idexregrt(rt_s),
    .idexregrd(rd_s), .idex_rs_data(rs_data_s), .idex_rt_data(rt_data_s),
    .idex_imm(imm_s), .idex_regwrite(regwrite_s), .idex_memread(memread_s),
    .idex_memwrite(memwrite_s), .idex_memtoreg(memtoreg_s), .idex_alusrc(alusrc_s),
    .idex_aluop(aluop_s), .stall_count(count_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_stall();
    logic dep;
    dep = (ex.rd == id.rs) || (id.uses_rt && ex.rd == id.rt);
    return id.valid && ex.valid && ex.memread && ex.rd != 4'd0 && dep && !flush && !rst;
  endfunction

  task automatic chk_outputs();
    chk("valid", 32'(idex_valid), 32'(ex.valid));
    chk("regrs", 32'(idexregrs), 32'(ex.rs));
    chk("regrt", 32'(idexregrt), 32'(ex.rt));
    chk("regrd", 32'(idexregrd), 32'(ex.rd));
    chk("rs_data", 32'(idex_rs_data), 32'(ex.rs_data));
    chk("rt_data", 32'(idex_rt_data), 32'(ex.rt_data));
    chk("imm", 32'(idex_imm), 32'(ex.imm));
    chk("ctrl", 32'({idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc}),
        32'({ex.regwrite, ex.memread, ex.memwrite, ex.memtoreg, ex.alusrc}));
    chk("aluop", 32'(idex_aluop), 32'(ex.aluop));
    chk("count", 32'(stall_count), 32'(m_cnt));
    chk("count_sat", 32'(count_s), 32'(m_cnt_s));
  endtask

  // One clock: check the combinational stall, advance the model, check registers.
  task automatic step();
    logic exp_stall;
    #1;
    exp_stall = model_stall();
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("stall_sat", 32'(stall_s), 32'(exp_stall));
    if (rst) begin
      ex = '0;
      m_cnt = '0;
      m_cnt_s = '0;
    end else begin
      ex = (flush || exp_stall) ? instr_t'('0) : id;
      if (exp_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (exp_stall && m_cnt_s != 4'hF) m_cnt_s = m_cnt_s + 4'd1;
    end
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r = instr_t'({$urandom, $urandom, $urandom});
    r.valid   = ($urandom_range(0, 7) != 0);
    r.rs      = 4'($urandom_range(0, 3));
    r.rt      = 4'($urandom_range(0, 3));
    r.rd      = 4'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    ex = '0;
    m_cnt = '0;
    m_cnt_s = '0;
    flush = 1'b0;

    // Reset with every ID field nonzero.
    rst = 1'b1;
    id = '1;
    step();
    step();
    chk("t1_valid", 32'(idex_valid), 32'd0);
    chk("t1_count", 32'(stall_count), 32'd0);
    rst = 1'b0;

    // Plain ALU instruction flows through in one cycle.
    id = '0;
    id.valid = 1'b1; id.rs = 4'd3; id.rt = 4'd4; id.rd = 4'd5;
    id.regwrite = 1'b1; id.aluop = 4'h2; id.rs_data = 16'h1234;
    step();
    chk("t2_rs", 32'(idexregrs), 32'd3);
    chk("t2_rd", 32'(idexregrd), 32'd5);
    chk("t2_rsd", 32'(idex_rs_data), 32'h1234);

    // Load rd=2 then a dependent reader of r2: one stall, one bubble.
    id = '0;
    id.valid = 1'b1; id.rs = 4'd1; id.rd = 4'd2; id.memread = 1'b1; id.regwrite = 1'b1;
    step();
    id = '0;
    id.valid = 1'b1; id.rs = 4'd2; id.rt = 4'd6; id.uses_rt = 1'b1; id.rd = 4'd8;
    id.regwrite = 1'b1;
    #1 chk("t3_stall", 32'(stall), 32'd1);
    step();
    chk("t3_bubble_valid", 32'(idex_valid), 32'd0);
    chk("t3_bubble_rd", 32'(idexregrd), 32'd0);
    chk("t3_no_restall", 32'(stall), 32'd0);
    step();
    chk("t3_dep_rs", 32'(idexregrs), 32'd2);
    chk("t3_count", 32'(stall_count), 32'd1);

    // Load to r0 never stalls; an immediate-form rt never matches.
    id = '0;
    id.valid = 1'b1; id.rd = 4'd0; id.memread = 1'b1;
    step();
    id = '0;
    id.valid = 1'b1; id.rs = 4'd0;
    #1 chk("t4_r0", 32'(stall), 32'd0);
    step();
    id = '0;
    id.valid = 1'b1; id.rd = 4'd2; id.memread = 1'b1;
    step();
    id = '0;
    id.valid = 1'b1; id.rs = 4'd5; id.rt = 4'd2; id.uses_rt = 1'b0;
    #1 chk("t4_imm", 32'(stall), 32'd0);
    step();

    // Flush beats a simultaneous hazard.
    id = '0;
    id.valid = 1'b1; id.rd = 4'd7; id.memread = 1'b1;
    step();
    id = '0;
    id.valid = 1'b1; id.rt = 4'd7; id.uses_rt = 1'b1; id.regwrite = 1'b1; id.memwrite = 1'b1;
    flush = 1'b1;
    #1 chk("t5_stall", 32'(stall), 32'd0);
    step();
    flush = 1'b0;
    chk("t5_valid", 32'(idex_valid), 32'd0);
    chk("t5_ctrl", 32'({idex_regwrite, idex_memwrite}), 32'd0);

    // Randomized traffic with frequent load-use pairs, flushes and resets.
    for (int i = 0; i < 600; i++) begin
      id = rand_instr();
      flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;
    flush = 1'b0;

    // Drive the narrow counter well past its ceiling.
    for (int i = 0; i < 20; i++) begin
      id = '0;
      id.valid = 1'b1; id.rd = 4'd9; id.memread = 1'b1;
      step();
      id = '0;
      id.valid = 1'b1; id.rs = 4'd9;
      step();
      step();
    end
    chk("t6_sat", 32'(count_s), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
